pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RV32I core. It merges per-stage stall requests into the stall vector that freezes the PC and pipeline registers. It turns EX-stage branch/jump decisions (`b_flag`/`b_target_addr`) into PC redirects and IF/ID + ID/EX flushes. When a fetch is outstanding at branch time, it holds the target until the fetch drains. It also keeps stall/branch statistics and a hang watchdog.

---
 rtl/pipe_ctrl_if.sv | 33 +++
 rtl/pipe_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: per-stage stall requests and the EX branch decision
// flowing into the controller, stall/flush/redirect and statistics flowing out.
interface pipe_ctrl_if;
    logic        if_stall_req_i;
    logic        id_stall_req_i;
    logic        ex_stall_req_i;
    logic        mem_stall_req_i;
    logic        ex_b_flag_i;
    logic [31:0] ex_b_target_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        pc_redirect_o;
    logic [31:0] pc_redirect_addr_o;
    logic [31:0] stall_cycles_o;
    logic [31:0] branch_count_o;
    logic        hang_o;

    // Core side: drives requests and the branch decision, observes control
    modport master (
        output if_stall_req_i, id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
        output ex_b_flag_i, ex_b_target_i,
        input  stall_o, flush_o, pc_redirect_o, pc_redirect_addr_o,
        input  stall_cycles_o, branch_count_o, hang_o
    );

    // Controller side
    modport slave (
        input  if_stall_req_i, id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
        input  ex_b_flag_i, ex_b_target_i,
        output stall_o, flush_o, pc_redirect_o, pc_redirect_addr_o,
        output stall_cycles_o, branch_count_o, hang_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage RV32I core.
// Merges stall requests into a freeze mask, converts EX branch decisions
// into PC redirects plus IF/ID, ID/EX flushes, parks the target while a
// fetch drains, and keeps stall/branch statistics and a hang watchdog.
module pipe_ctrl #(
    parameter int unsigned HANG_LIMIT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   io_bus
);
    localparam logic [15:0] LIMIT   = 16'(HANG_LIMIT);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_tgt;
    logic [31:0] w_tgt_next;
    logic        w_accept;
    logic        w_flush;
    logic        w_redirect;
    logic [31:0] w_redirect_addr;
    logic [5:0]  w_stall;

    logic [31:0] r_stall_cycles;
    logic [31:0] r_branch_count;
    logic [15:0] r_run_cnt;
    logic [15:0] w_run_next;
    logic        r_hang;

    // State and pending-target registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_tgt   <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_tgt   <= w_tgt_next;
        end
    end

    // Branch acceptance, flush and redirect decisions; reset forces all off
    always_comb begin
        w_state_next    = r_state;
        w_tgt_next      = r_tgt;
        w_accept        = 1'b0;
        w_flush         = 1'b0;
        w_redirect      = 1'b0;
        w_redirect_addr = 32'd0;
        case (r_state)
            ST_RUN: begin
                // A branch frozen in EX by an ex/mem stall waits for the
                // first unstalled cycle, so it is accepted exactly once.
                if (io_bus.ex_b_flag_i && !io_bus.ex_stall_req_i &&
                    !io_bus.mem_stall_req_i) begin
                    w_accept = 1'b1;
                    w_flush  = 1'b1;
                    if (!io_bus.if_stall_req_i) begin
                        w_redirect      = 1'b1;
                        w_redirect_addr = io_bus.ex_b_target_i;
                    end else begin
                        // Fetch in flight: park the target until it drains
                        w_tgt_next   = io_bus.ex_b_target_i;
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Keep flushing so the returning stale fetch is discarded
                w_flush = 1'b1;
                if (!io_bus.if_stall_req_i && !io_bus.mem_stall_req_i) begin
                    w_redirect      = 1'b1;
                    w_redirect_addr = r_tgt;
                    w_state_next    = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
        if (rst) begin
            w_accept        = 1'b0;
            w_flush         = 1'b0;
            w_redirect      = 1'b0;
            w_redirect_addr = 32'd0;
        end
    end

    // Freeze mask: deepest requesting stage wins; a redirect unfreezes PC and IF/ID
    always_comb begin
        w_stall = 6'b000000;
        if (io_bus.mem_stall_req_i)
            w_stall = 6'b011111;
        else if (io_bus.ex_stall_req_i)
            w_stall = 6'b001111;
        else if (io_bus.id_stall_req_i && !w_flush)
            w_stall = 6'b000111;
        else if (io_bus.if_stall_req_i)
            w_stall = 6'b000011;
        if (w_redirect)
            w_stall[1:0] = 2'b00;
        if (rst)
            w_stall = 6'b000000;
    end

    // Watchdog run length: counts consecutive PC-stall cycles, saturating at the limit
    always_comb begin
        w_run_next = 16'd0;
        if (w_stall[0])
            w_run_next = (r_run_cnt >= LIMIT) ? LIMIT : r_run_cnt + 16'd1;
    end

    // Saturating statistics counters and sticky hang flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_branch_count <= 32'd0;
            r_run_cnt      <= 16'd0;
            r_hang         <= 1'b0;
        end else begin
            if (w_stall[0] && r_stall_cycles != CNT_MAX)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_accept && r_branch_count != CNT_MAX)
                r_branch_count <= r_branch_count + 32'd1;
            r_run_cnt <= w_run_next;
            if (w_run_next == LIMIT)
                r_hang <= 1'b1;
        end
    end

    assign io_bus.stall_o            = w_stall;
    assign io_bus.flush_o            = w_flush;
    assign io_bus.pc_redirect_o      = w_redirect;
    assign io_bus.pc_redirect_addr_o = w_redirect_addr;
    assign io_bus.stall_cycles_o     = r_stall_cycles;
    assign io_bus.branch_count_o     = r_branch_count;
    assign io_bus.hang_o             = r_hang;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of single-cycle vectors plus
// hand-written multi-cycle sequences (drain, EX-held branch, watchdog, reset).
module tb_pipe_ctrl;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.HANG_LIMIT(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_r, id_r, ex_r, mem_r, flag;
        logic [31:0] tgt;
        logic [5:0]  e_stall;
        logic        e_flush, e_redir;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic i_f, input logic i_d, input logic e_x,
                         input logic m_m, input logic fl, input logic [31:0] t);
        bus.if_stall_req_i  = i_f;
        bus.id_stall_req_i  = i_d;
        bus.ex_stall_req_i  = e_x;
        bus.mem_stall_req_i = m_m;
        bus.ex_b_flag_i     = fl;
        bus.ex_b_target_i   = t;
    endtask

    // Advance to one time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_comb(input string name, input logic [5:0] s, input logic f,
                            input logic r, input logic [31:0] a);
        chk({name, ".stall"}, 32'(bus.stall_o), 32'(s));
        chk({name, ".flush"}, 32'(bus.flush_o), 32'(f));
        chk({name, ".redir"}, 32'(bus.pc_redirect_o), 32'(r));
        chk({name, ".addr"}, bus.pc_redirect_addr_o, a);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        //        if id ex mem flag target         stall      fl redir addr
        vecs[0]  = '{0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h0};
        vecs[1]  = '{0, 1, 0, 1, 0, 32'h0,        6'b011111, 0, 0, 32'h0};
        vecs[2]  = '{1, 0, 0, 0, 0, 32'h0,        6'b000011, 0, 0, 32'h0};
        vecs[3]  = '{0, 0, 1, 0, 0, 32'h0,        6'b001111, 0, 0, 32'h0};
        vecs[4]  = '{0, 1, 0, 0, 0, 32'h0,        6'b000111, 0, 0, 32'h0};
        vecs[5]  = '{1, 1, 0, 0, 0, 32'h0,        6'b000111, 0, 0, 32'h0};
        vecs[6]  = '{0, 0, 0, 0, 1, 32'h100,      6'b000000, 1, 1, 32'h100};
        vecs[7]  = '{0, 1, 0, 0, 1, 32'h180,      6'b000000, 1, 1, 32'h180};
        vecs[8]  = '{0, 0, 1, 0, 1, 32'h1C0,      6'b001111, 0, 0, 32'h0};
        vecs[9]  = '{0, 0, 0, 1, 1, 32'h1E0,      6'b011111, 0, 0, 32'h0};
        vecs[10] = '{0, 0, 0, 0, 0, 32'h55,       6'b000000, 0, 0, 32'h0};

        drive(0, 0, 0, 0, 0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        // Reset state, with a branch and stalls presented during reset
        drive(1, 1, 1, 1, 1, 32'hDEAD);
        #2;
        chk_comb("in_reset", 6'b0, 0, 0, 32'h0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("rst.stall_cycles", bus.stall_cycles_o, 32'd0);
        chk("rst.branch_count", bus.branch_count_o, 32'd0);
        chk("rst.hang", 32'(bus.hang_o), 32'd0);
        tick();

        // Table: one cycle per vector, all applied from RUN
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].if_r, vecs[i].id_r, vecs[i].ex_r, vecs[i].mem_r,
                  vecs[i].flag, vecs[i].tgt);
            #2;
            $display("vec %0d: stall=%b flush=%b redir=%b addr=%h", i,
                     bus.stall_o, bus.flush_o, bus.pc_redirect_o, bus.pc_redirect_addr_o);
            chk_comb($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush,
                     vecs[i].e_redir, vecs[i].e_addr);
            tick();
        end
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("tab.branch_count", bus.branch_count_o, 32'd2);
        chk("tab.stall_cycles", bus.stall_cycles_o, 32'd7);
        tick();

        // Branch during an outstanding fetch: 4 drain cycles, then redirect
        do_reset();
        $display("seq drain: branch to 0x200 with fetch outstanding");
        drive(1, 0, 0, 0, 1, 32'h200);
        #2;
        chk_comb("drain.c0", 6'b000011, 1, 0, 32'h0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            // flag held with a bogus target: must be ignored in DRAIN
            drive(1, 1, 0, 0, 1, 32'h999);
            #2;
            chk_comb($sformatf("drain.c%0d", c), 6'b000011, 1, 0, 32'h0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        chk_comb("drain.release", 6'b000000, 1, 1, 32'h200);
        tick();
        #2;
        chk_comb("drain.after", 6'b000000, 0, 0, 32'h0);
        chk("drain.branch_count", bus.branch_count_o, 32'd1);
        chk("drain.stall_cycles", bus.stall_cycles_o, 32'd4);
        tick();

        // Branch held in EX by an EX stall: accepted once when the stall drops
        $display("seq exhold: branch 0x240 under ex stall");
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 1, 0, 1, 32'h240);
            #2;
            chk_comb($sformatf("exhold.c%0d", c), 6'b001111, 0, 0, 32'h0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 32'h240);
        #2;
        chk_comb("exhold.accept", 6'b000000, 1, 1, 32'h240);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        chk_comb("exhold.after", 6'b000000, 0, 0, 32'h0);
        chk("exhold.branch_count", bus.branch_count_o, 32'd2);
        tick();

        // Watchdog with limit 8: ten MEM stall cycles
        do_reset();
        $display("seq watchdog: mem stall for 10 cycles");
        for (int c = 1; c <= 10; c++) begin
            drive(0, 0, 0, 1, 0, 32'h0);
            tick();
            if (c == 7) chk("wd.hang_after7", 32'(bus.hang_o), 32'd0);
            if (c == 8) chk("wd.hang_after8", 32'(bus.hang_o), 32'd1);
        end
        drive(0, 0, 0, 0, 0, 32'h0);
        tick();
        tick();
        chk("wd.hang_sticky", 32'(bus.hang_o), 32'd1);
        chk("wd.stall_cycles", bus.stall_cycles_o, 32'd10);

        // Reset while in DRAIN drops the parked target
        do_reset();
        $display("seq rstdrain: enter DRAIN with 0x300 then reset");
        drive(1, 0, 0, 0, 1, 32'h300);
        #2;
        chk_comb("rstdrain.enter", 6'b000011, 1, 0, 32'h0);
        tick();
        drive(0, 1, 0, 0, 1, 32'h300);
        rst = 1'b1;
        #2;
        chk_comb("rstdrain.in_rst", 6'b000000, 0, 0, 32'h0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("rstdrain.branch_count", bus.branch_count_o, 32'd0);
        chk("rstdrain.hang", 32'(bus.hang_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_comb($sformatf("rstdrain.post%0d", c), 6'b000000, 0, 0, 32'h0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
